// File: rtl/pipeline_debug_console.sv
// pipeline_debug_console
//   Board-level run/debug controller for the FPGA build of the 5-stage MIPS pipeline.
//   Issues the pipeline advance pulse (single-step, free-run, free-run until halt),
//   forwards the switch-selected register index to the register-file debug port and
//   shows the returned value in hex on a multiplexed, paged 7-segment display.
//
// Ports
//   clock, reset_n   system clock, asynchronous active-low reset
//   step_btn         raw step pushbutton (active-high, bouncy)
//   page_btn         raw page pushbutton (active-high, bouncy)
//   run_sw           0 = single-step, 1 = run
//   halt_req         halt level from the pipeline, honoured only while running
//   reg_index        switch-selected register number
//   reg_value        value returned by the register-file debug port
//   reg_index_out    synchronised register index
//   cpu_step         one-clock pipeline advance enable
//   cycle_count      number of cpu_step pulses since reset
//   anodes           active-low digit enables
//   cathodes         active-low segments, [0]=a .. [6]=g
//   dp               active-low decimal point (lit on digit 0 while halted)
module pipeline_debug_console #(
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned REG_IDX_W       = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned SCAN_DIV        = 16,
  parameter int unsigned RUN_DIV         = 24
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  step_btn,
  input  logic                  page_btn,
  input  logic                  run_sw,
  input  logic                  halt_req,
  input  logic [REG_IDX_W-1:0]  reg_index,
  input  logic [DATA_W-1:0]     reg_value,
  output logic [REG_IDX_W-1:0]  reg_index_out,
  output logic                  cpu_step,
  output logic [31:0]           cycle_count,
  output logic [NUM_DIGITS-1:0] anodes,
  output logic [6:0]            cathodes,
  output logic                  dp
);

  localparam int unsigned NumPages = DATA_W / (4 * NUM_DIGITS);
  localparam int unsigned PageW    = (NumPages > 1) ? $clog2(NumPages) : 1;
  localparam int unsigned DigitW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DbW      = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {StStep, StRun, StHalt} state_e;

  // ---------------------------------------------------------------------------
  // Synchronisers. Button index 0 = step, 1 = page.
  // ---------------------------------------------------------------------------
  logic [1:0]           btn_sync1_q, btn_sync2_q;
  logic                 run_sync1_q, run_sync2_q;
  logic                 halt_sync1_q, halt_sync2_q;
  logic [REG_IDX_W-1:0] idx_sync1_q, idx_sync2_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_sync1_q  <= '0;
      btn_sync2_q  <= '0;
      run_sync1_q  <= 1'b0;
      run_sync2_q  <= 1'b0;
      halt_sync1_q <= 1'b0;
      halt_sync2_q <= 1'b0;
      idx_sync1_q  <= '0;
      idx_sync2_q  <= '0;
    end else begin
      btn_sync1_q  <= {page_btn, step_btn};
      btn_sync2_q  <= btn_sync1_q;
      run_sync1_q  <= run_sw;
      run_sync2_q  <= run_sync1_q;
      halt_sync1_q <= halt_req;
      halt_sync2_q <= halt_sync1_q;
      idx_sync1_q  <= reg_index;
      idx_sync2_q  <= idx_sync1_q;
    end
  end

  assign reg_index_out = idx_sync2_q;

  // ---------------------------------------------------------------------------
  // Debounce: the accepted level flips after DEBOUNCE_CYCLES consecutive samples
  // that differ from it; a sample equal to the accepted level restarts the count.
  // ---------------------------------------------------------------------------
  logic [1:0]     btn_level_q, btn_press_q;
  logic [DbW-1:0] db_cnt_q [2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_level_q <= '0;
      btn_press_q <= '0;
      for (int b = 0; b < 2; b++) db_cnt_q[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        btn_press_q[b] <= 1'b0;
        if (btn_sync2_q[b] == btn_level_q[b]) begin
          db_cnt_q[b] <= '0;
        end else if (db_cnt_q[b] == DbW'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt_q[b]    <= '0;
          btn_level_q[b] <= btn_sync2_q[b];
          btn_press_q[b] <= btn_sync2_q[b];
        end else begin
          db_cnt_q[b] <= db_cnt_q[b] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Run-control FSM
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [RUN_DIV-1:0] run_cnt_q, run_cnt_d;
  logic               cpu_step_q, cpu_step_d;
  logic [31:0]        cycle_count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StStep;
      run_cnt_q     <= '0;
      cpu_step_q    <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      cpu_step_q <= cpu_step_d;
      if (cpu_step_q) cycle_count_q <= cycle_count_q + 32'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    cpu_step_d = 1'b0;
    unique case (state_q)
      StStep: begin
        if (run_sync2_q) begin
          state_d   = StRun;
          run_cnt_d = '0;
        end else if (btn_press_q[0]) begin
          cpu_step_d = 1'b1;
        end
      end
      StRun: begin
        // Leaving RUN takes priority over halting, and halting suppresses the pulse.
        if (!run_sync2_q) begin
          state_d = StStep;
        end else if (halt_sync2_q) begin
          state_d = StHalt;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
          if (&run_cnt_q) cpu_step_d = 1'b1;
        end
      end
      StHalt: begin
        if (!run_sync2_q) state_d = StStep;
      end
      default: state_d = StStep;
    endcase
    // A step press right after a RUN pulse must not create back-to-back pulses.
    if (cpu_step_q) cpu_step_d = 1'b0;
  end

  assign cpu_step    = cpu_step_q;
  assign cycle_count = cycle_count_q;

  // ---------------------------------------------------------------------------
  // Paging
  // ---------------------------------------------------------------------------
  logic [PageW-1:0] page_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      page_q <= '0;
    end else if (btn_press_q[1]) begin
      page_q <= (page_q == PageW'(NumPages - 1)) ? '0 : page_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan. Blank until the first scan tick; the snapshot is refreshed only
  // at the start of each frame so a frame never mixes two values.
  // ---------------------------------------------------------------------------
  logic [SCAN_DIV-1:0] scan_cnt_q;
  logic                scan_on_q;
  logic [DigitW-1:0]   digit_q;
  logic [DATA_W-1:0]   snap_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt_q <= '0;
      scan_on_q  <= 1'b0;
      digit_q    <= '0;
      snap_q     <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
      if (&scan_cnt_q) begin
        if (!scan_on_q) begin
          scan_on_q <= 1'b1;
          digit_q   <= '0;
          snap_q    <= reg_value;
        end else if (digit_q == DigitW'(NUM_DIGITS - 1)) begin
          digit_q <= '0;
          snap_q  <= reg_value;
        end else begin
          digit_q <= digit_q + 1'b1;
        end
      end
    end
  end

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  logic [31:0] nib_sel;
  logic [3:0]  nib;

  always_comb begin
    nib_sel  = 32'(page_q) * NUM_DIGITS + 32'(digit_q);
    nib      = 4'(snap_q >> (nib_sel * 4));
    anodes   = '1;
    cathodes = 7'h7F;
    dp       = 1'b1;
    if (scan_on_q) begin
      anodes   = ~(NUM_DIGITS'(1) << digit_q);
      cathodes = hex_to_seg(nib);
      dp       = ~((digit_q == '0) && (state_q == StHalt));
    end
  end

endmodule

// File: tb/tb_pipeline_debug_console.sv
// Self-checking bench for pipeline_debug_console with short debounce/scan/run dividers.
module tb_pipeline_debug_console;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        step_btn = 1'b0, page_btn = 1'b0, run_sw = 1'b0, halt_req = 1'b0;
  logic [4:0]  reg_index = 5'd0;
  logic [31:0] reg_value = 32'h1234ABCD;
  logic [4:0]  reg_index_out;
  logic        cpu_step;
  logic [31:0] cycle_count;
  logic [3:0]  anodes;
  logic [6:0]  cathodes;
  logic        dp;

  pipeline_debug_console #(
    .NUM_DIGITS(4), .DATA_W(32), .REG_IDX_W(5),
    .DEBOUNCE_CYCLES(4), .SCAN_DIV(2), .RUN_DIV(3)
  ) dut (
    .clock(clock), .reset_n(reset_n), .step_btn(step_btn), .page_btn(page_btn),
    .run_sw(run_sw), .halt_req(halt_req), .reg_index(reg_index), .reg_value(reg_value),
    .reg_index_out(reg_index_out), .cpu_step(cpu_step), .cycle_count(cycle_count),
    .anodes(anodes), .cathodes(cathodes), .dp(dp)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [6:0]  exp_q[$];

  // Pulse monitor: total pulses since reset and back-to-back detection.
  int unsigned tot_q = 0;
  logic        prev_step_q = 1'b0;
  logic        consec_err_q = 1'b0;

  always @(posedge clock) begin
    #1;
    if (!reset_n) begin
      tot_q       <= 0;
      prev_step_q <= 1'b0;
    end else begin
      if (cpu_step) tot_q <= tot_q + 1;
      if (cpu_step && prev_step_q) consec_err_q <= 1'b1;
      prev_step_q <= cpu_step;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic wait_digit(input int i);
    logic [3:0] one;
    logic [3:0] want;
    int k;
    one  = 4'b0001;
    want = ~(one << i);
    k    = 0;
    while (anodes !== want && k < 64) begin
      @(negedge clock);
      k++;
    end
    if (anodes !== want) check("digit_timeout", 32'(anodes), 32'(want));
  endtask

  // Compares one fresh frame against the next four queued segment patterns.
  task automatic check_frame(input string tag);
    wait_digit(3);
    for (int i = 0; i < 4; i++) begin
      wait_digit(i);
      if (exp_q.size() == 0) check({tag, "_underflow"}, 32'd1, 32'd0);
      else check(tag, 32'(cathodes), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic press_page();
    page_btn = 1'b1;
    repeat (8) @(negedge clock);
    page_btn = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic push4(input logic [6:0] d0, input logic [6:0] d1,
                       input logic [6:0] d2, input logic [6:0] d3);
    exp_q.push_back(d0);
    exp_q.push_back(d1);
    exp_q.push_back(d2);
    exp_q.push_back(d3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned p0;
    int unsigned dp_cnt;
    int k;

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_anodes", 32'(anodes), 32'hF);
    check("rst_cathodes", 32'(cathodes), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_cpu_step", 32'(cpu_step), 32'd0);
    check("rst_cycle_count", cycle_count, 32'd0);
    check("rst_idx", 32'(reg_index_out), 32'd0);
    reset_n = 1'b1;

    // Reset in the middle of RUN once cycle_count reaches 5
    run_sw = 1'b1;
    k = 0;
    while (cycle_count != 32'd5 && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("run_to_5", cycle_count, 32'd5);
    reset_n = 1'b0;
    #1;
    check("async_cycle_count", cycle_count, 32'd0);
    check("async_anodes", 32'(anodes), 32'hF);
    check("async_cathodes", 32'(cathodes), 32'h7F);
    check("async_cpu_step", 32'(cpu_step), 32'd0);
    @(negedge clock);
    run_sw = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // First digit appears 2^SCAN_DIV clocks after release
    repeat (3) @(negedge clock);
    check("blank_before_first_tick", 32'(anodes), 32'hF);
    @(negedge clock);
    check("first_digit", 32'(anodes), 32'hE);

    // Bouncy step press: exactly one pulse
    p0 = tot_q;
    step_btn = 1'b1; @(negedge clock);
    step_btn = 1'b0; @(negedge clock);
    step_btn = 1'b1; @(negedge clock);
    repeat (20) @(negedge clock);
    step_btn = 1'b0;
    repeat (12) @(negedge clock);
    check("step_pulses", tot_q - p0, 32'd1);
    check("step_cycle_count", cycle_count, 32'd1);

    // Paging of 32'h1234ABCD
    push4(7'h21, 7'h46, 7'h03, 7'h08);
    check_frame("page0_seg");
    press_page();
    push4(7'h19, 7'h30, 7'h24, 7'h79);
    check_frame("page1_seg");
    press_page();
    push4(7'h21, 7'h46, 7'h03, 7'h08);
    check_frame("page_wrap_seg");

    // RUN, HALT, back to STEP
    run_sw = 1'b1;
    p0 = tot_q;
    repeat (64) @(negedge clock);
    check("run_pulses_7_to_8", 32'((tot_q - p0 >= 7) && (tot_q - p0 <= 8)), 32'd1);
    halt_req = 1'b1;
    repeat (4) @(negedge clock);
    p0 = tot_q;
    repeat (32) @(negedge clock);
    check("halt_no_pulses", tot_q - p0, 32'd0);
    wait_digit(0);
    check("halt_dp_digit0", 32'(dp), 32'd0);
    wait_digit(1);
    check("halt_dp_digit1", 32'(dp), 32'd1);
    halt_req = 1'b0;
    p0 = tot_q;
    repeat (24) @(negedge clock);
    check("halt_sticky", tot_q - p0, 32'd0);
    run_sw = 1'b0;
    repeat (4) @(negedge clock);
    wait_digit(3);
    wait_digit(0);
    check("step_dp_digit0", 32'(dp), 32'd1);
    check("count_matches_pulses", cycle_count, 32'(tot_q));

    // Register index synchroniser latency
    reg_index = 5'd17;
    @(negedge clock);
    check("idx_after_1", 32'(reg_index_out), 32'd0);
    @(negedge clock);
    check("idx_after_2", 32'(reg_index_out), 32'd17);

    // reg_value change mid-frame is deferred to the next frame
    push4(7'h21, 7'h46, 7'h03, 7'h08);
    wait_digit(3);
    wait_digit(0);
    check("midframe_d0", 32'(cathodes), 32'(exp_q.pop_front()));
    reg_value = 32'h0000_0000;
    for (int i = 1; i < 4; i++) begin
      wait_digit(i);
      check("midframe_old", 32'(cathodes), 32'(exp_q.pop_front()));
    end
    push4(7'h40, 7'h40, 7'h40, 7'h40);
    check_frame("next_frame_new");

    dp_cnt = 32'(consec_err_q);
    check("no_back_to_back", dp_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
